// File: rtl/enigma_pkg.sv
// Shared constants, rotor tables, FSM state type and mod-26 helpers for the
// multi-cycle Enigma engine.
package enigma_pkg;

    localparam int ALPHA       = 26;
    localparam int NUM_WIRINGS = 5;

    typedef logic [4:0]                   code_t;
    typedef code_t [0:ALPHA-1]            perm_t;
    typedef perm_t [0:NUM_WIRINGS-1]      perm_set_t;
    // Wide enough for LW+1 at the largest legal LW, so every width shares it.
    typedef logic [8:0]                   wide_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STEP = 3'd1,
        S_FWD  = 3'd2,
        S_REFL = 3'd3,
        S_BWD  = 3'd4
    } state_t;

    // Turns a 26-letter wiring string (first letter = entry for A) into codes.
    function automatic perm_t str_to_perm(input logic [8*ALPHA-1:0] s);
        perm_t      p;
        logic [7:0] ch;
        for (int i = 0; i < ALPHA; i++) begin
            ch   = s[8*(ALPHA-1-i) +: 8];
            p[i] = code_t'(ch - 8'd65);
        end
        return p;
    endfunction

    // Inverse permutation, used for the return path through a rotor.
    function automatic perm_t invert_perm(input perm_t p);
        perm_t q;
        q = '0;
        for (int i = 0; i < ALPHA; i++) begin
            q[p[i]] = code_t'(i);
        end
        return q;
    endfunction

    localparam perm_set_t WIRING = '{
        str_to_perm("EKMFLGDQVZNTOWYHXUSPAIBRCJ"),
        str_to_perm("AJDKSIRUXBLHWTMCQGZNPYFVOE"),
        str_to_perm("BDFHJLCPRTXVZNYEIWGAKMOUSQ"),
        str_to_perm("ESOVPZJAYQUIRHXLNFTGKDCMWB"),
        str_to_perm("VZBRGITYUPSDNHLXAWMKQCEJFO")
    };

    localparam perm_set_t INVERSE = '{
        invert_perm(WIRING[0]),
        invert_perm(WIRING[1]),
        invert_perm(WIRING[2]),
        invert_perm(WIRING[3]),
        invert_perm(WIRING[4])
    };

    // Notch letters Q, E, V, J, Z for rotors I..V.
    localparam code_t [0:NUM_WIRINGS-1] NOTCH = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25};

    localparam perm_t REFLECTOR_B = str_to_perm("YRUHQSLDPXNGOKMIEBFZCWVJAT");

    // (a + b) mod 26 for operands already in 0..25.
    function automatic wide_t add26(input wide_t a, input wide_t b);
        wide_t s;
        s = a + b;
        if (s >= 9'd26) begin
            s = s - 9'd26;
        end else begin
            s = s;
        end
        return s;
    endfunction

    // (a - b) mod 26 for operands already in 0..25.
    function automatic wide_t sub26(input wide_t a, input wide_t b);
        wide_t d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = a + 9'd26 - b;
        end
        return d;
    endfunction

endpackage

// File: rtl/enigma_stepper.sv
// Combinational stepping rule: which rotor slots advance on the next key
// press, including the middle-rotor double step.
module enigma_stepper
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = 3,
    parameter int LW         = 5
) (
    input  logic [NUM_ROTORS-1:0][LW-1:0] pos,
    output logic [NUM_ROTORS-1:0]         step_en
);

    logic [NUM_ROTORS-1:0] at_notch_s;

    // Notch detection per slot, then the simultaneous advance rules.
    always_comb begin
        at_notch_s = '0;
        step_en    = '0;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            at_notch_s[i] = (pos[i] == LW'(NOTCH[(NUM_ROTORS-1-i) % NUM_WIRINGS]));
        end
        step_en[0] = 1'b1;
        for (int i = 1; i < NUM_ROTORS; i++) begin
            step_en[i] = at_notch_s[i-1] | ((i <= NUM_ROTORS-2) & at_notch_s[i]);
        end
    end

endmodule

// File: rtl/enigma_core.sv
// Multi-cycle Enigma engine: steps the rotors, then walks one letter through
// the rotors, reflector and back at one lookup per cycle.
module enigma_core
    import enigma_pkg::*;
#(
    parameter int NUM_ROTORS = 3,
    parameter int LW         = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LW-1:0]            in_char,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LW-1:0]            out_char,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_sel,
    input  logic [LW-1:0]            cfg_pos,
    input  logic [LW-1:0]            cfg_ring,
    output logic                     busy,
    output logic [NUM_ROTORS*LW-1:0] pos_out
);

    localparam int IW = $clog2(NUM_ROTORS);

    state_t                         state_r, state_n;
    logic [IW-1:0]                  idx_r, idx_n;
    logic [LW-1:0]                  x_r, x_n;
    logic [NUM_ROTORS-1:0][LW-1:0]  pos_r, pos_n;
    logic [NUM_ROTORS-1:0][LW-1:0]  ring_r, ring_n;
    logic                           out_valid_r, out_valid_n;
    logic [LW-1:0]                  out_char_r, out_char_n;
    logic                           in_ready_r, in_ready_n;
    logic                           busy_r, busy_n;

    logic [NUM_ROTORS-1:0]          step_en_s;
    logic [LW-1:0]                  slot_pos_s, slot_ring_s;
    logic [2:0]                     slot_w_s;
    wide_t                          shift_s;
    code_t                          addr_s, tab_s;
    logic [LW-1:0]                  lookup_s, reflect_s;
    logic                           accept_s, is_letter_s;

    enigma_stepper #(.NUM_ROTORS(NUM_ROTORS), .LW(LW)) u_stepper (
        .pos     (pos_r),
        .step_en (step_en_s)
    );

    // Select the position, ring and wiring of the slot currently visited.
    always_comb begin
        slot_pos_s  = '0;
        slot_ring_s = '0;
        slot_w_s    = 3'd0;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            if (idx_r == IW'(i)) begin
                slot_pos_s  = pos_r[i];
                slot_ring_s = ring_r[i];
                slot_w_s    = 3'((NUM_ROTORS-1-i) % NUM_WIRINGS);
            end else begin
                slot_pos_s  = slot_pos_s;
                slot_ring_s = slot_ring_s;
                slot_w_s    = slot_w_s;
            end
        end
    end

    // One rotor lookup (forward or inverse) and the reflector lookup.
    always_comb begin
        shift_s   = sub26(wide_t'(slot_pos_s), wide_t'(slot_ring_s));
        addr_s    = code_t'(add26(wide_t'(x_r), shift_s));
        tab_s     = (state_r == S_BWD) ? INVERSE[slot_w_s][addr_s] : WIRING[slot_w_s][addr_s];
        lookup_s  = LW'(sub26(wide_t'(tab_s), shift_s));
        reflect_s = LW'(REFLECTOR_B[x_r[4:0]]);
    end

    // Next-state, datapath and output-register updates.
    always_comb begin
        state_n     = state_r;
        idx_n       = idx_r;
        x_n         = x_r;
        pos_n       = pos_r;
        ring_n      = ring_r;
        out_valid_n = out_valid_r;
        out_char_n  = out_char_r;
        accept_s    = in_valid & in_ready_r;
        is_letter_s = (in_char < LW'(ALPHA));
        case (state_r)
            S_IDLE: begin
                out_valid_n = out_valid_r & ~out_ready;
                for (int i = 0; i < NUM_ROTORS; i++) begin
                    if (cfg_we && (cfg_sel == 3'(i))) begin
                        pos_n[i]  = cfg_pos;
                        ring_n[i] = cfg_ring;
                    end else begin
                        pos_n[i]  = pos_r[i];
                        ring_n[i] = ring_r[i];
                    end
                end
                if (accept_s && is_letter_s) begin
                    x_n     = in_char;
                    state_n = S_STEP;
                end else if (accept_s) begin
                    out_valid_n = 1'b1;
                    out_char_n  = in_char;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_STEP: begin
                for (int i = 0; i < NUM_ROTORS; i++) begin
                    pos_n[i] = step_en_s[i] ? LW'(add26(wide_t'(pos_r[i]), 9'd1)) : pos_r[i];
                end
                idx_n   = '0;
                state_n = S_FWD;
            end
            S_FWD: begin
                x_n = lookup_s;
                if (idx_r == IW'(NUM_ROTORS-1)) begin
                    state_n = S_REFL;
                end else begin
                    idx_n = idx_r + IW'(1);
                end
            end
            S_REFL: begin
                x_n     = reflect_s;
                idx_n   = IW'(NUM_ROTORS-1);
                state_n = S_BWD;
            end
            S_BWD: begin
                x_n = lookup_s;
                if (idx_r == IW'(0)) begin
                    state_n     = S_IDLE;
                    out_valid_n = 1'b1;
                    out_char_n  = lookup_s;
                end else begin
                    idx_n = idx_r - IW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        in_ready_n = (state_n == S_IDLE) & ~out_valid_n;
        busy_n     = (state_n != S_IDLE);
    end

    // State, datapath and registered outputs; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            idx_r       <= '0;
            x_r         <= '0;
            pos_r       <= '0;
            ring_r      <= '0;
            out_valid_r <= 1'b0;
            out_char_r  <= '0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            idx_r       <= idx_n;
            x_r         <= x_n;
            pos_r       <= pos_n;
            ring_r      <= ring_n;
            out_valid_r <= out_valid_n;
            out_char_r  <= out_char_n;
            in_ready_r  <= in_ready_n;
            busy_r      <= busy_n;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_char  = out_char_r;
    assign busy      = busy_r;
    assign pos_out   = pos_r;

endmodule

// File: tb/tb_enigma_core.sv
// Scoreboard bench for enigma_core: a three-rotor build and a five-rotor,
// six-bit build, both checked against a letter-level Enigma model.
module tb_enigma_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- DUT A: N=3, LW=5 ----------------
    logic        rst_n = 1'b0;
    logic        in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b1, busy3;
    logic [4:0]  in_char3 = 5'd0, out_char3, cfg_pos3 = 5'd0, cfg_ring3 = 5'd0;
    logic        cfg_we3 = 1'b0;
    logic [2:0]  cfg_sel3 = 3'd0;
    logic [14:0] pos_out3;

    enigma_core #(.NUM_ROTORS(3), .LW(5)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_char(in_char3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_char(out_char3), .cfg_we(cfg_we3), .cfg_sel(cfg_sel3),
        .cfg_pos(cfg_pos3), .cfg_ring(cfg_ring3), .busy(busy3), .pos_out(pos_out3)
    );

    // ---------------- DUT B: N=5, LW=6 ----------------
    logic        rst5_n = 1'b0;
    logic        in_valid5 = 1'b0, in_ready5, out_valid5, out_ready5 = 1'b1, busy5;
    logic [5:0]  in_char5 = 6'd0, out_char5, cfg_pos5 = 6'd0, cfg_ring5 = 6'd0;
    logic        cfg_we5 = 1'b0;
    logic [2:0]  cfg_sel5 = 3'd0;
    logic [29:0] pos_out5;

    enigma_core #(.NUM_ROTORS(5), .LW(6)) dut5 (
        .clk(clk), .rst_n(rst5_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_char(in_char5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_char(out_char5), .cfg_we(cfg_we5), .cfg_sel(cfg_sel5),
        .cfg_pos(cfg_pos5), .cfg_ring(cfg_ring5), .busy(busy5), .pos_out(pos_out5)
    );

    // ---------------- reference model ----------------
    string ROT[5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                      "BDFHJLCPRTXVZNYEIWGAKMOUSQ", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                      "VZBRGITYUPSDNHLXAWMKQCEJFO"};
    string REFL    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    string NOTCHES = "QEVJZ";

    int m3_pos[8], m3_ring[8], m5_pos[8], m5_ring[8];

    typedef struct { int ch; int inch; logic [63:0] pos; } exp_t;
    exp_t q3[$];
    exp_t q5[$];

    function automatic int wire_of(input int w, input int k);
        string s;
        s = ROT[w];
        return int'(s.getc(k)) - 65;
    endfunction

    function automatic int inv_of(input int w, input int v);
        for (int j = 0; j < 26; j++) if (wire_of(w, j) == v) return j;
        return 0;
    endfunction

    function automatic bit at_notch(input int n, input int i, input int v);
        return (int'(NOTCHES.getc((n-1-i) % 5)) - 65) == v;
    endfunction

    function automatic void step_pos(input int n, input int p[8], output int q[8]);
        bit adv;
        q = p;
        for (int i = 0; i < n; i++) begin
            adv = (i == 0);
            if (i >= 1 && at_notch(n, i-1, p[i-1])) adv = 1'b1;
            if (i >= 1 && i <= n-2 && at_notch(n, i, p[i])) adv = 1'b1;
            if (adv) q[i] = (p[i] + 1) % 26;
        end
    endfunction

    function automatic int encipher(input int n, input int c, input int p[8], input int r[8]);
        int x, s, w;
        x = c;
        for (int i = 0; i < n; i++) begin
            w = (n-1-i) % 5; s = (p[i] - r[i] + 26) % 26;
            x = (wire_of(w, (x + s) % 26) - s + 26) % 26;
        end
        x = int'(REFL.getc(x)) - 65;
        for (int i = n-1; i >= 0; i--) begin
            w = (n-1-i) % 5; s = (p[i] - r[i] + 26) % 26;
            x = (inv_of(w, (x + s) % 26) - s + 26) % 26;
        end
        return x;
    endfunction

    function automatic logic [63:0] pack_pos(input int n, input int lw, input int p[8]);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(p[i]) << (lw * i));
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [63:0] act, input logic [63:0] other);
        checks++;
        if (act === other) begin
            errors++;
            $display("FAIL %s: got %0d, must differ from %0d", name, act, other);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out3: got %0d, expected no output", out_char3);
            end else begin
                e = q3.pop_front();
                check("out_char3", 64'(out_char3), 64'(e.ch));
                check("pos_out3", 64'(pos_out3), e.pos);
                if (e.inch < 26) check_ne("no_self3", 64'(out_char3), 64'(e.inch));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst5_n && out_valid5 && out_ready5) begin
            if (q5.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out5: got %0d, expected no output", out_char5);
            end else begin
                e = q5.pop_front();
                check("out_char5", 64'(out_char5), 64'(e.ch));
                check("pos_out5", 64'(pos_out5), e.pos);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send3(input int c, input bit fixed, input int fixed_c);
        int np[8]; int e; int k; exp_t x;
        in_valid3 = 1'b1; in_char3 = 5'(c);
        k = 0;
        while (!in_ready3 && k < 200) begin @(posedge clk); #1; k++; end
        if (!in_ready3) begin
            checks++; errors++;
            $display("FAIL accept3: got in_ready=0, expected 1 within 200 cycles");
            in_valid3 = 1'b0;
            return;
        end
        if (c < 26) begin
            step_pos(3, m3_pos, np); m3_pos = np;
            e = encipher(3, c, m3_pos, m3_ring);
        end else e = c;
        x.ch = fixed ? fixed_c : e; x.inch = c; x.pos = pack_pos(3, 5, m3_pos);
        q3.push_back(x);
        @(posedge clk); #1;
        in_valid3 = 1'b0;
    endtask

    task automatic wait3();
        int k;
        k = 0;
        while (q3.size() != 0 && k < 200) begin @(posedge clk); k++; end
        #1;
        if (q3.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain3: got %0d pending, expected 0", q3.size());
            q3.delete();
        end
    endtask

    task automatic cfg3(input int sel, input int p, input int r);
        cfg_we3 = 1'b1; cfg_sel3 = 3'(sel); cfg_pos3 = 5'(p); cfg_ring3 = 5'(r);
        @(posedge clk); #1;
        cfg_we3 = 1'b0;
        if (sel < 3) begin m3_pos[sel] = p; m3_ring[sel] = r; end
    endtask

    task automatic send5(input int c, input bit expect_out);
        int np[8]; int k; exp_t x;
        in_valid5 = 1'b1; in_char5 = 6'(c);
        k = 0;
        while (!in_ready5 && k < 200) begin @(posedge clk); #1; k++; end
        if (!in_ready5) begin
            checks++; errors++;
            $display("FAIL accept5: got in_ready=0, expected 1 within 200 cycles");
            in_valid5 = 1'b0;
            return;
        end
        step_pos(5, m5_pos, np); m5_pos = np;
        if (expect_out) begin
            x.ch = encipher(5, c, m5_pos, m5_ring); x.inch = c; x.pos = pack_pos(5, 6, m5_pos);
            q5.push_back(x);
        end
        @(posedge clk); #1;
        in_valid5 = 1'b0;
    endtask

    task automatic wait5();
        int k;
        k = 0;
        while (q5.size() != 0 && k < 200) begin @(posedge clk); k++; end
        #1;
        if (q5.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain5: got %0d pending, expected 0", q5.size());
            q5.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int ds_exp[3][3];
        int aaaaa[5], held, k;
        ds_exp = '{'{21, 3, 0}, '{22, 4, 0}, '{23, 5, 1}};
        aaaaa  = '{1, 3, 25, 6, 14};
        for (int i = 0; i < 8; i++) begin m3_pos[i] = 0; m3_ring[i] = 0; m5_pos[i] = 0; m5_ring[i] = 0; end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready3), 64'd0);
        check("rst_out_valid", 64'(out_valid3), 64'd0);
        check("rst_out_char", 64'(out_char3), 64'd0);
        check("rst_busy", 64'(busy3), 64'd0);
        check("rst_pos", 64'(pos_out3), 64'd0);
        rst_n = 1'b1; rst5_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready3), 64'd1);

        // AAAAA -> BDZGO
        for (int i = 0; i < 5; i++) send3(0, 1'b1, aaaaa[i]);
        wait3();
        check("aaaaa_pos", 64'(pos_out3), 64'd5);

        // Double step from A,D,U
        cfg3(2, 0, 0); cfg3(1, 3, 0); cfg3(0, 20, 0);
        for (int j = 0; j < 3; j++) begin
            send3(int'($urandom_range(0, 25)), 1'b0, 0);
            wait3();
            check("double_step_pos", 64'(pos_out3),
                  64'(ds_exp[j][0]) | (64'(ds_exp[j][1]) << 5) | (64'(ds_exp[j][2]) << 10));
        end

        // Reciprocity: BDZGO from AAA decodes to AAAAA
        cfg3(0, 0, 0); cfg3(1, 0, 0); cfg3(2, 0, 0);
        for (int i = 0; i < 5; i++) send3(aaaaa[i], 1'b1, 0);
        wait3();

        // Backpressure
        out_ready3 = 1'b0;
        send3(int'($urandom_range(0, 25)), 1'b0, 0);
        k = 0;
        while (!out_valid3 && k < 50) begin @(posedge clk); #1; k++; end
        check("bp_valid_rise", 64'(out_valid3), 64'd1);
        held = int'(out_char3);
        in_valid3 = 1'b1; in_char3 = 5'd7;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", 64'(out_valid3), 64'd1);
            check("bp_char_hold", 64'(out_char3), 64'(held));
            check("bp_in_ready", 64'(in_ready3), 64'd0);
        end
        check("bp_no_accept_busy", 64'(busy3), 64'd0);
        check("bp_no_accept_pos", 64'(pos_out3), pack_pos(3, 5, m3_pos));
        in_valid3 = 1'b0; out_ready3 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", 64'(in_ready3), 64'd1);
        check("bp_release_valid", 64'(out_valid3), 64'd0);

        // Non-letter echo after one edge
        send3(31, 1'b0, 0);
        check("nl_valid", 64'(out_valid3), 64'd1);
        check("nl_char", 64'(out_char3), 64'd31);
        check("nl_busy", 64'(busy3), 64'd0);
        wait3();

        // Config write while busy is ignored
        send3(int'($urandom_range(0, 25)), 1'b0, 0);
        check("cfg_busy_state", 64'(busy3), 64'd1);
        cfg_we3 = 1'b1; cfg_sel3 = 3'd0; cfg_pos3 = 5'd7; cfg_ring3 = 5'd3;
        @(posedge clk); #1; @(posedge clk); #1;
        cfg_we3 = 1'b0;
        wait3();
        send3(int'($urandom_range(0, 25)), 1'b0, 0);
        wait3();

        // Out-of-range slot select is ignored
        cfg3(5, 9, 9);
        check("cfg_sel5_pos", 64'(pos_out3), pack_pos(3, 5, m3_pos));
        send3(int'($urandom_range(0, 25)), 1'b0, 0);
        wait3();

        // Random rotor setup and 1000 random letters
        for (int s = 0; s < 3; s++) cfg3(s, int'($urandom_range(0, 25)), int'($urandom_range(0, 25)));
        for (int i = 0; i < 1000; i++) send3(int'($urandom_range(0, 25)), 1'b0, 0);
        wait3();

        // Five-rotor, six-bit build: rings 1, positions 0, input A
        for (int s = 0; s < 5; s++) begin
            cfg_we5 = 1'b1; cfg_sel5 = 3'(s); cfg_pos5 = 6'd0; cfg_ring5 = 6'd1;
            @(posedge clk); #1;
            m5_ring[s] = 1;
        end
        cfg_we5 = 1'b0;
        send5(0, 1'b1);
        wait5();

        // Reset in the middle of the forward walk
        send5(int'($urandom_range(0, 25)), 1'b0);
        @(posedge clk); #1;
        check("abort_busy", 64'(busy5), 64'd1);
        rst5_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid5), 64'd0);
        check("abort_pos", 64'(pos_out5), 64'd0);
        check("abort_in_ready_low", 64'(in_ready5), 64'd0);
        for (int i = 0; i < 8; i++) begin m5_pos[i] = 0; m5_ring[i] = 0; end
        @(posedge clk); #1;
        rst5_n = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 64'(in_ready5), 64'd1);
        check("abort_busy_clear", 64'(busy5), 64'd0);
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_output", 64'(out_valid5), 64'd0);
        send5(int'($urandom_range(0, 25)), 1'b1);
        wait5();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
